// File: rtl/calc_alu_scheduler.sv
// ---------------------------------------------------------------------------
// calc_alu_scheduler
//
// Shares one small calculator ALU between two requesters. Requests are
// arbitrated round-robin, each accepted operation runs to completion, and the
// result is returned through a valid/ready response channel.
//
// ADD/SUB/AND/OR/XOR/NOT take one EXEC cycle. MUL (shift-add) and DIV
// (restoring shift-subtract) take DATA_W EXEC cycles. DIV by zero finishes in
// one cycle with an all-ones result and rsp_err set.
//
// Parameters:
//   DATA_W    operand width, result width is 2*DATA_W
//   SUB_SIGN  1: SUB returns the two's-complement 2W-bit difference
//             0: SUB clamps to zero when A < B
//
// Optional feature (macro CALC_SCHED_STATS_EN):
//   adds op_count (16b, completed responses) and div0_count (8b, completed
//   responses with rsp_err). Both saturate and clear on rst.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req0_* / req1_*               valid, a, b, op in; ready out
//   rsp_valid/rsp_ready           response handshake
//   rsp_id, rsp_result, rsp_err   response payload (registered)
//   busy                          FSM is not IDLE
// ---------------------------------------------------------------------------
module calc_alu_scheduler #(
    parameter int DATA_W   = 4,
    parameter bit SUB_SIGN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [DATA_W-1:0]     req0_a,
    input  logic [DATA_W-1:0]     req0_b,
    input  logic [2:0]            req0_op,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_W-1:0]     req1_a,
    input  logic [DATA_W-1:0]     req1_b,
    input  logic [2:0]            req1_op,
    output logic                  req1_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [2*DATA_W-1:0]   rsp_result,
    output logic                  rsp_err,
    output logic                  busy
`ifdef CALC_SCHED_STATS_EN
    ,
    output logic [15:0]           op_count,
    output logic [7:0]            div0_count
`endif
);

    localparam int W  = DATA_W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t             state_q;
    logic               last_grant_q;
    logic [W-1:0]       a_q, b_q;
    logic [2:0]         op_q;
    logic               id_q;
    logic [CW-1:0]      cnt_q;
    logic [2*W-1:0]     prod_q;
    logic [W-1:0]       rem_q, quo_q;
    logic               rsp_valid_q, rsp_id_q, rsp_err_q, busy_q;
    logic [2*W-1:0]     rsp_result_q;

    // ---------------- arbitration ----------------
    // On a tie the requester opposite last_grant wins; otherwise whoever is
    // valid. With nobody valid grant idles at 0, which is harmless because a
    // handshake also needs valid.
    logic         grant;
    logic         accept;
    logic [W-1:0] sel_a, sel_b;
    logic [2:0]   sel_op;

    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_grant_q;
        else                          grant = req1_valid && !req0_valid;
    end

    assign req0_ready = (state_q == S_IDLE) && !grant && !rst;
    assign req1_ready = (state_q == S_IDLE) &&  grant && !rst;
    assign accept     = (state_q == S_IDLE) && (req0_valid || req1_valid);

    assign sel_a  = grant ? req1_a  : req0_a;
    assign sel_b  = grant ? req1_b  : req0_b;
    assign sel_op = grant ? req1_op : req0_op;

    // ---------------- single-cycle ALU ----------------
    logic [2*W-1:0] a_ext, b_ext, single_res;
    assign a_ext = {{W{1'b0}}, a_q};
    assign b_ext = {{W{1'b0}}, b_q};

    always_comb begin
        single_res = '0;
        case (op_q)
            OP_ADD: single_res = a_ext + b_ext;
            OP_SUB: begin
                if (SUB_SIGN || (a_q >= b_q)) single_res = a_ext - b_ext;
                else                          single_res = '0;
            end
            OP_AND: single_res = a_ext & b_ext;
            OP_OR:  single_res = a_ext | b_ext;
            OP_XOR: single_res = a_ext ^ b_ext;
            OP_MUL, OP_DIV: single_res = '0;
            default: single_res = {{W{1'b0}}, ~a_q};
        endcase
    end

    // ---------------- iterative MUL / DIV step ----------------
    logic           is_iter, last_step;
    logic [2*W-1:0] mul_add, prod_d;
    logic [W:0]     div_trial;
    logic           div_ge;
    logic [W-1:0]   rem_sub, rem_d, quo_d;

    assign is_iter   = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
    assign last_step = (cnt_q == CW'(W-1));

    // MUL: add the partial product for bit cnt of B, shifted into place.
    assign mul_add = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
    assign prod_d  = prod_q + mul_add;

    // DIV: bring down the next dividend bit (MSB first) and subtract when it
    // fits. The remainder always ends below B, so the W-bit wrap-around
    // difference is exact.
    assign div_trial = {rem_q, a_q[CW'(W-1) - cnt_q]};
    assign div_ge    = div_trial >= {1'b0, b_q};
    assign rem_sub   = div_trial[W-1:0] - b_q;
    assign rem_d     = div_ge ? rem_sub : div_trial[W-1:0];
    assign quo_d     = {quo_q[W-2:0], div_ge};

    // ---------------- FSM and registered outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            prod_q       <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q          <= sel_a;
                        b_q          <= sel_b;
                        op_q         <= sel_op;
                        id_q         <= grant;
                        last_grant_q <= grant;
                        cnt_q        <= '0;
                        prod_q       <= '0;
                        rem_q        <= '0;
                        quo_q        <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_iter) begin
                        prod_q <= prod_d;
                        rem_q  <= rem_d;
                        quo_q  <= quo_d;
                        cnt_q  <= cnt_q + CW'(1);
                        if (last_step) begin
                            rsp_result_q <= (op_q == OP_MUL) ? prod_d
                                                             : {{W{1'b0}}, quo_d};
                            rsp_err_q    <= 1'b0;
                            rsp_id_q     <= id_q;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= S_DONE;
                        end
                    end else begin
                        // Single-cycle ops, plus DIV by zero which is flagged.
                        rsp_result_q <= (op_q == OP_DIV) ? '1 : single_res;
                        rsp_err_q    <= (op_q == OP_DIV);
                        rsp_id_q     <= id_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    // No accept in the cycle that retires a response.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;

`ifdef CALC_SCHED_STATS_EN
    logic [15:0] op_count_q;
    logic [7:0]  div0_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q   <= '0;
            div0_count_q <= '0;
        end else if ((state_q == S_DONE) && rsp_ready) begin
            if (op_count_q != '1)
                op_count_q <= op_count_q + 16'd1;
            if (rsp_err_q && (div0_count_q != '1))
                div0_count_q <= div0_count_q + 8'd1;
        end
    end

    assign op_count   = op_count_q;
    assign div0_count = div0_count_q;
`endif

endmodule

// File: tb/tb_calc_alu_scheduler.sv
// Bench for calc_alu_scheduler: table of directed vectors, hand-written
// multi-cycle sequences (alternating grants, response stall, reset mid-MUL)
// and randomized transactions checked against an arithmetic reference model.
module tb_calc_alu_scheduler;

    localparam int W  = 4;
    localparam bit SS = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [2:0]     req0_op, req1_op;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [2*W-1:0] rsp_result;
`ifdef CALC_SCHED_STATS_EN
    logic [15:0]    op_count;
    logic [7:0]     div0_count;
`endif

    calc_alu_scheduler #(.DATA_W(W), .SUB_SIGN(SS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
`ifdef CALC_SCHED_STATS_EN
        ,
        .op_count   (op_count),
        .div0_count (div0_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int excl_viol = 0;
    int model_lg = 1;

    always @(negedge clk) if (req0_ready && req1_ready) excl_viol++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the opcode definitions.
    function automatic logic [2*W:0] model(input int a, input int b, input int op);
        int r;
        logic e;
        int rmask;
        rmask = (1 << (2*W)) - 1;
        e = 1'b0;
        case (op)
            0: r = a + b;
            1: r = SS ? ((a - b) & rmask) : ((a < b) ? 0 : a - b);
            2: r = a * b;
            3: if (b == 0) begin r = rmask; e = 1'b1; end else r = a / b;
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: r = (~a) & ((1 << W) - 1);
        endcase
        return {e, r[2*W-1:0]};
    endfunction

    function automatic int model_k(input int op, input int b);
        return (op == 2 || (op == 3 && b != 0)) ? W : 1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_lg = 1;
    endtask

    // One transaction: raise the valids in mask, wait for the handshake,
    // measure latency, optionally stall the response, then consume it.
    task automatic issue(input logic [1:0] mask,
                         input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] op0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] op1,
                         input int stall,
                         output int gid, output int lat, output logic [2*W-1:0] res,
                         output logic err, output logic rid,
                         output logic busy_ok, output logic hold_ok);
        bit got;
        got = 0; gid = -1; lat = 0; res = '0; err = 1'b0; rid = 1'b0;
        busy_ok = 1'b1; hold_ok = 1'b1;
        req0_a = a0; req0_b = b0; req0_op = op0;
        req1_a = a1; req1_b = b1; req1_op = op1;
        req0_valid = mask[0];
        req1_valid = mask[1];
        rsp_ready = (stall == 0);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin gid = 0; got = 1; end
            else if (req1_valid && req1_ready) begin gid = 1; got = 1; end
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!got) return;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) break;
            if (!busy) busy_ok = 1'b0;
        end
        if (!busy) busy_ok = 1'b0;
        res = rsp_result; err = rsp_err; rid = rsp_id;
        if (!rsp_valid) return;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            if (!rsp_valid || rsp_result !== res || rsp_err !== err || rsp_id !== rid ||
                req0_ready || req1_ready)
                hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        if (rsp_valid || busy) hold_ok = 1'b0;
    endtask

    typedef struct {
        logic [1:0]     mask;
        logic [W-1:0]   a, b;
        logic [2:0]     op;
        int             stall;
        int             exp_id;
        logic [2*W-1:0] exp_res;
        logic           exp_err;
        int             exp_lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int gid, lat;
        logic [2*W-1:0] res;
        logic err, rid, bok, hok;
        int ids[4];
        logic [2*W-1:0] rs[4];
        int tms[4];
        int n;
        logic held;

        vecs[0] = '{2'b01, 4'd5,  4'd3,  3'd0, 0, 0, 8'd8,   1'b0, 1};
        vecs[1] = '{2'b10, 4'd4,  4'd7,  3'd2, 0, 1, 8'd28,  1'b0, 4};
        vecs[2] = '{2'b01, 4'd11, 4'd3,  3'd3, 2, 0, 8'd3,   1'b0, 4};
        vecs[3] = '{2'b10, 4'd7,  4'd0,  3'd3, 0, 1, 8'hFF,  1'b1, 1};
        vecs[4] = '{2'b01, 4'd3,  4'd5,  3'd1, 1, 0, 8'hFE,  1'b0, 1};
        vecs[5] = '{2'b10, 4'd12, 4'd10, 3'd4, 0, 1, 8'd8,   1'b0, 1};
        vecs[6] = '{2'b01, 4'd12, 4'd3,  3'd5, 0, 0, 8'd15,  1'b0, 1};
        vecs[7] = '{2'b10, 4'd15, 4'd15, 3'd2, 3, 1, 8'd225, 1'b0, 4};
        vecs[8] = '{2'b01, 4'd15, 4'd1,  3'd3, 0, 0, 8'd15,  1'b0, 4};
        vecs[9] = '{2'b10, 4'd15, 4'd15, 3'd0, 0, 1, 8'd30,  1'b0, 1};

        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_result", rsp_result, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("reset_ready0", req0_ready, 0);
        check("reset_ready1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        model_lg = 1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].mask, vecs[i].a, vecs[i].b, vecs[i].op,
                  vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].stall,
                  gid, lat, res, err, rid, bok, hok);
            check($sformatf("vec%0d_grant", i), gid, vecs[i].exp_id);
            check($sformatf("vec%0d_id", i), rid, vecs[i].exp_id);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_busy", i), bok, 1);
            check($sformatf("vec%0d_hold", i), hok, 1);
            $display("vec %0d: op=%0d a=%0d b=%0d id=%0d result=%0d err=%0d lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, rid, res, err, lat);
        end

        // Alternating grants with both requesters always valid
        do_reset();
        @(posedge clk);
        #1;
        req0_a = 4'd15; req0_b = 4'd1; req0_op = 3'd6;
        req1_a = 4'd12; req1_b = 4'd0; req1_op = 3'd7;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                ids[n] = rsp_id; rs[n] = rsp_result; tms[n] = c;
                $display("alt rsp %0d: id=%0d result=%0d cycle=%0d", n, rsp_id, rsp_result, c);
                n++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("alt_count", n, 4);
        for (int i = 0; i < n; i++) begin
            check($sformatf("alt%0d_id", i), ids[i], i % 2);
            check($sformatf("alt%0d_result", i), rs[i], (i % 2) ? 8'd3 : 8'd14);
            if (i > 0) check($sformatf("alt%0d_spacing", i), tms[i] - tms[i-1], 3);
        end
        model_lg = 1;
        repeat (3) @(posedge clk);
        #1;

        // Response stall, then reset in the middle of a MUL
        do_reset();
        @(posedge clk);
        #1;
        req0_a = 4'd4; req0_b = 4'd7; req0_op = 3'd2;
        req1_a = 4'd3; req1_b = 4'd3; req1_op = 3'd2;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && !rsp_valid; c++) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_reached_done", rsp_valid, 1);
        held = 1'b1;
        for (int s = 0; s < 10; s++) begin
            @(posedge clk);
            #1;
            if (!rsp_valid || rsp_result !== 8'd28 || rsp_id !== 1'b0 || req0_ready || req1_ready)
                held = 1'b0;
        end
        check("stall_held", held, 1);
        $display("stall: result=%0d id=%0d held=%0d", rsp_result, rsp_id, held);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("stall_next_grant_req1", req1_ready, 1);
        check("stall_no_req0", req0_ready, 0);
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midmul_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_result", rsp_result, 0);
        check("rst_id", rsp_id, 0);
        check("rst_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_lg = 1;
        #1;
        check("post_rst_tie_req0", req0_ready, 1);
        check("post_rst_tie_req1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        held = 1'b0;
        for (int s = 0; s < 8; s++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) held = 1'b1;
        end
        check("rst_dropped_op", held, 0);

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] mask;
            logic [W-1:0] a0, b0, a1, b1;
            logic [2:0] op0, op1;
            int egid, ea, eb, eop;
            logic [2*W:0] m;
            mask = 2'($urandom_range(1, 3));
            a0 = W'($urandom); b0 = W'($urandom); op0 = 3'($urandom);
            a1 = W'($urandom); b1 = W'($urandom); op1 = 3'($urandom);
            egid = (mask == 2'b11) ? (1 - model_lg) : ((mask == 2'b10) ? 1 : 0);
            model_lg = egid;
            ea  = egid ? a1 : a0;
            eb  = egid ? b1 : b0;
            eop = egid ? op1 : op0;
            m = model(ea, eb, eop);
            issue(mask, a0, b0, op0, a1, b1, op1, $urandom_range(0, 3),
                  gid, lat, res, err, rid, bok, hok);
            check($sformatf("rnd%0d_grant", i), gid, egid);
            check($sformatf("rnd%0d_id", i), rid, egid);
            check($sformatf("rnd%0d_result", i), res, m[2*W-1:0]);
            check($sformatf("rnd%0d_err", i), err, m[2*W]);
            check($sformatf("rnd%0d_latency", i), lat, model_k(eop, eb));
            check($sformatf("rnd%0d_hold", i), hok & bok, 1);
            $display("rnd %0d: mask=%0d id=%0d op=%0d a=%0d b=%0d result=%0d err=%0d lat=%0d",
                     i, mask, rid, eop, ea, eb, res, err, lat);
        end

        check("ready_exclusive", excl_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

endmodule
